// File: rtl/multi_one_shot_pkg.sv
// one_shot_pkg: shared types and sizing helper for the multi-channel one-shot
package one_shot_pkg;

    typedef enum logic [1:0] {ES_OFF, ES_RISE, ES_FALL, ES_BOTH} edge_sel_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLD} state_t;

    // Counter must hold the larger of the pulse and hold-off reload values.
    function automatic int cnt_width(input int pulse_len, input int holdoff);
        int m;
        m = pulse_len > holdoff ? pulse_len : holdoff;
        m = m < 1 ? 1 : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/multi_one_shot_if.sv
// multi_one_shot_if: per-channel input lines, edge selects and pulse/status outputs
interface multi_one_shot_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0]   sig_in;
    logic [2*N_CH-1:0] edge_sel;
    logic [N_CH-1:0]   sig_out;
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   miss;

    modport master (output sig_in, edge_sel, input sig_out, busy, miss);
    modport slave  (input sig_in, edge_sel, output sig_out, busy, miss);
endinterface

// File: rtl/multi_one_shot_ch.sv
// one_shot_ch: one channel of synchroniser, edge detect, pulse FSM and counter
module one_shot_ch
    import one_shot_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   PULSE_LEN   = 1,
    parameter int   HOLDOFF     = 0,
    parameter bit   RETRIGGER   = 1'b0,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic      clk,
    input  logic      RSTn,
    input  logic      sig_in,
    input  edge_sel_t edge_sel,
    output logic      sig_out,
    output logic      busy,
    output logic      miss
);
    localparam int CW = cnt_width(PULSE_LEN, HOLDOFF);
    localparam logic [CW-1:0] PL = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] HL = CW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);

    logic [SYNC_STAGES-1:0] sync;
    logic s, h, rise_r, fall_r, q, miss_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    state_t state, nxt;

    assign s       = sync[SYNC_STAGES-1];
    assign q       = (edge_sel[0] & rise_r) | (edge_sel[1] & fall_r);
    assign sig_out = state == ST_ACTIVE;
    assign busy    = state != ST_IDLE;

    // Synchronise the line, keep one cycle of history and register the raw edges.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync   <= {SYNC_STAGES{IDLE_LEVEL}};
            h      <= IDLE_LEVEL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], sig_in};
            h      <= s;
            rise_r <= s & ~h;
            fall_r <= ~s & h;
        end
    end

    // Pulse FSM state, counter and miss flag registers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            miss  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            miss  <= miss_nxt;
        end
    end

    // Next state: a discarded edge flags miss but never stalls the running count.
    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        miss_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                nxt     = q ? ST_ACTIVE : ST_IDLE;
                cnt_nxt = q ? PL : cnt;
            end
            ST_ACTIVE: begin
                if (q && RETRIGGER) begin
                    cnt_nxt = PL;
                end else begin
                    miss_nxt = q;
                    if (cnt == '0) begin
                        nxt     = HOLDOFF > 0 ? ST_HOLD : ST_IDLE;
                        cnt_nxt = HL;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                miss_nxt = q;
                nxt      = cnt == '0 ? ST_IDLE : ST_HOLD;
                cnt_nxt  = cnt == '0 ? cnt : cnt - 1'b1;
            end
            default: nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/multi_one_shot.sv
// multi_one_shot: N independent one-shot channels sliced from a shared bus
module multi_one_shot
    import one_shot_pkg::*;
#(
    parameter int   N_CH        = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   PULSE_LEN   = 1,
    parameter int   HOLDOFF     = 0,
    parameter bit   RETRIGGER   = 1'b0,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input logic              clk,
    input logic              RSTn,
    multi_one_shot_if.slave  bus
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        one_shot_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .PULSE_LEN  (PULSE_LEN),
            .HOLDOFF    (HOLDOFF),
            .RETRIGGER  (RETRIGGER),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_ch (
            .clk     (clk),
            .RSTn    (RSTn),
            .sig_in  (bus.sig_in[i]),
            .edge_sel(edge_sel_t'(bus.edge_sel[2*i+:2])),
            .sig_out (bus.sig_out[i]),
            .busy    (bus.busy[i]),
            .miss    (bus.miss[i])
        );
    end

endmodule

// File: tb/tb_multi_one_shot.sv
// tb_multi_one_shot: three configurations driven in parallel against a remaining-time model
module tb_multi_one_shot;
    localparam int N = 4;

    logic clk = 1'b0;
    logic RSTn = 1'b0;
    logic [N-1:0] sig_in = '1;
    logic [2*N-1:0] edge_sel = '1;
    int pass_n = 0;
    int total_n = 0;

    multi_one_shot_if #(.N_CH(N)) b0 ();
    multi_one_shot_if #(.N_CH(N)) b1 ();
    multi_one_shot_if #(.N_CH(N)) b2 ();

    assign b0.sig_in = sig_in;
    assign b1.sig_in = sig_in;
    assign b2.sig_in = sig_in;
    assign b0.edge_sel = edge_sel;
    assign b1.edge_sel = edge_sel;
    assign b2.edge_sel = edge_sel;

    multi_one_shot #(.N_CH(N)) u0 (.clk(clk), .RSTn(RSTn), .bus(b0));
    multi_one_shot #(.N_CH(N), .PULSE_LEN(4), .HOLDOFF(3)) u1 (.clk(clk), .RSTn(RSTn), .bus(b1));
    multi_one_shot #(.N_CH(N), .PULSE_LEN(4), .HOLDOFF(3), .RETRIGGER(1'b1)) u2 (.clk(clk), .RSTn(RSTn), .bus(b2));

    logic [3*N-1:0] obs [3];
    assign obs[0] = {b0.sig_out, b0.busy, b0.miss};
    assign obs[1] = {b1.sig_out, b1.busy, b1.miss};
    assign obs[2] = {b2.sig_out, b2.busy, b2.miss};

    always #5 clk = ~clk;

    // Model: p = high cycles still owed, hd = hold-off cycles still owed.
    int pl [3] = '{1, 4, 4};
    int hdo [3] = '{0, 3, 3};
    int rt [3] = '{0, 0, 1};
    logic [N-1:0] hist [5];
    int p [3][N];
    int hd [3][N];
    logic [N-1:0] mv [3];
    logic [3*N-1:0] expv [3];

    function automatic void build_exp();
        for (int c = 0; c < 3; c++) begin
            logic [N-1:0] o, b;
            for (int ch = 0; ch < N; ch++) begin
                o[ch] = p[c][ch] > 0;
                b[ch] = p[c][ch] > 0 || hd[c][ch] > 0;
            end
            expv[c] = {o, b, mv[c]};
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 5; k++) hist[k] = '1;
        for (int c = 0; c < 3; c++) begin
            mv[c] = '0;
            for (int ch = 0; ch < N; ch++) begin
                p[c][ch] = 0;
                hd[c][ch] = 0;
            end
        end
        build_exp();
    endfunction

    // An input sampled at edge e reaches the pulse logic at edge e+3.
    task automatic tick();
        @(posedge clk);
        if (!RSTn) begin
            model_reset();
        end else begin
            for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sig_in;
            for (int c = 0; c < 3; c++) begin
                for (int ch = 0; ch < N; ch++) begin
                    logic r, f, q, m;
                    int sel;
                    sel = int'(edge_sel[2*ch+:2]);
                    r = hist[3][ch] && !hist[4][ch];
                    f = !hist[3][ch] && hist[4][ch];
                    q = sel == 1 ? r : sel == 2 ? f : sel == 3 ? (r || f) : 1'b0;
                    m = 1'b0;
                    if (p[c][ch] > 0) begin
                        if (q && rt[c] != 0) p[c][ch] = pl[c];
                        else begin
                            m = q;
                            p[c][ch]--;
                            if (p[c][ch] == 0) hd[c][ch] = hdo[c];
                        end
                    end else if (hd[c][ch] > 0) begin
                        m = q;
                        hd[c][ch]--;
                    end else if (q) begin
                        p[c][ch] = pl[c];
                    end
                    mv[c][ch] = m;
                end
            end
            build_exp();
        end
        #1;
    endtask

    task automatic test_reset();
        sig_in = '1;
        edge_sel = '1;
        RSTn = 1'b0;
        model_reset();
        repeat (3) tick();
        for (int c = 0; c < 3; c++) begin
            total_n++;
            if (obs[c] !== '0) $display("FAIL reset_hold c%0d: got %b want 0", c, obs[c]);
            else pass_n++;
        end
        RSTn = 1'b1;
        repeat (20) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                total_n++;
                if (obs[c] !== '0) $display("FAIL reset_release c%0d: got %b want 0", c, obs[c]);
                else pass_n++;
            end
        end
    endtask

    task automatic test_edges_default();
        logic [1:0] sels [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
        logic lvls [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic pulse_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 4; t++) begin
            edge_sel = {6'b0, sels[t]};
            sig_in[0] = lvls[t];
            for (int i = 0; i < 8; i++) begin
                tick();
                total_n++;
                if (b0.sig_out[0] !== (i == 3 && pulse_exp[t])) $display("FAIL edge_timing t%0d i%0d: got %b want %b", t, i, b0.sig_out[0], i == 3 && pulse_exp[t]);
                else pass_n++;
                for (int c = 0; c < 3; c++) begin
                    total_n++;
                    if (obs[c] !== expv[c]) $display("FAIL edge_model c%0d: got %b want %b", c, obs[c], expv[c]);
                    else pass_n++;
                end
            end
        end
    endtask

    task automatic test_holdoff(input int n_tog, input string name, input int w_out1, input int w_busy1, input int w_miss1, input int w_out2, input int w_miss2);
        int o1, bz1, m1, o2, m2;
        o1 = 0; bz1 = 0; m1 = 0; o2 = 0; m2 = 0;
        sig_in = '1;
        edge_sel = 8'b10;
        repeat (15) tick();
        for (int i = 0; i < 30; i++) begin
            if (i < n_tog) sig_in[0] = ~sig_in[0];
            tick();
            o1 += int'(b1.sig_out[0]);
            bz1 += int'(b1.busy[0]);
            m1 += int'(b1.miss[0]);
            o2 += int'(b2.sig_out[0]);
            m2 += int'(b2.miss[0]);
            for (int c = 0; c < 3; c++) begin
                total_n++;
                if (obs[c] !== expv[c]) $display("FAIL %s_model c%0d: got %b want %b", name, c, obs[c], expv[c]);
                else pass_n++;
            end
        end
        total_n++;
        if ({o1, bz1, m1, o2, m2} !== {w_out1, w_busy1, w_miss1, w_out2, w_miss2})
            $display("FAIL %s_counts: got out=%0d busy=%0d miss=%0d rout=%0d rmiss=%0d want %0d %0d %0d %0d %0d", name, o1, bz1, m1, o2, m2, w_out1, w_busy1, w_miss1, w_out2, w_miss2);
        else pass_n++;
    endtask

    task automatic test_multi_channel();
        int silent;
        silent = 0;
        sig_in = '1;
        edge_sel = {2'b10, 2'b10, 2'b00, 2'b10};
        repeat (15) tick();
        sig_in = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            tick();
            silent += int'(b0.sig_out[1]) + int'(b0.miss[1]);
            if (i == 3) begin
                total_n++;
                if (b0.sig_out !== 4'b0101) $display("FAIL multi_same_cycle: got %b want 0101", b0.sig_out);
                else pass_n++;
            end
            for (int c = 0; c < 3; c++) begin
                total_n++;
                if (obs[c] !== expv[c]) $display("FAIL multi_model c%0d: got %b want %b", c, obs[c], expv[c]);
                else pass_n++;
            end
        end
        total_n++;
        if (silent !== 0) $display("FAIL multi_ch1_silent: got %0d want 0", silent);
        else pass_n++;
    endtask

    task automatic test_reset_mid_pulse();
        int o1;
        sig_in = '1;
        edge_sel = 8'b10;
        repeat (15) tick();
        sig_in[0] = 1'b0;
        repeat (5) tick();
        total_n++;
        if (b1.sig_out[0] !== 1'b1) $display("FAIL mid_pulse_active: got %b want 1", b1.sig_out[0]);
        else pass_n++;
        #2 RSTn = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            total_n++;
            if (obs[c] !== '0) $display("FAIL async_reset c%0d: got %b want 0", c, obs[c]);
            else pass_n++;
        end
        sig_in[0] = 1'b1;
        repeat (2) tick();
        RSTn = 1'b1;
        for (int t = 0; t < 2; t++) begin
            o1 = 0;
            if (t == 1) sig_in[0] = 1'b0;
            repeat (14) begin
                tick();
                o1 += int'(b1.sig_out[0]);
                for (int c = 0; c < 3; c++) begin
                    total_n++;
                    if (obs[c] !== expv[c]) $display("FAIL post_reset_model c%0d: got %b want %b", c, obs[c], expv[c]);
                    else pass_n++;
                end
            end
            total_n++;
            if (o1 !== 4 * t) $display("FAIL post_reset_pulse t%0d: got %0d want %0d", t, o1, 4 * t);
            else pass_n++;
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            if ($urandom_range(3) == 0) sig_in = N'($urandom);
            if ($urandom_range(15) == 0) edge_sel = (2*N)'($urandom);
            tick();
            for (int c = 0; c < 3; c++) begin
                total_n++;
                if (obs[c] !== expv[c]) $display("FAIL random_model c%0d: got %b want %b", c, obs[c], expv[c]);
                else pass_n++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_edges_default();
        test_holdoff(7, "holdoff", 4, 7, 3, 10, 0);
        test_holdoff(3, "retrigger", 4, 7, 1, 6, 0);
        test_multi_channel();
        test_reset_mid_pulse();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/multi_one_shot.md
Name: multi_one_shot

Overview:
- N-channel, parametrised successor to the single-channel one-shot used on the UART RX line.
- Per channel, the block:
  - synchronises an asynchronous input;
  - detects a selectable edge (rise, fall, both, off);
  - emits an output pulse of programmable length;
  - enforces an optional hold-off window after the pulse.
- Typical use: start-bit falling-edge detection and other strobes in the UART datapath.

Parameters:
- N_CH, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser depth per channel; legal range >= 2.
- PULSE_LEN, 1: output pulse width in clk cycles; legal range >= 1.
- HOLDOFF, 0: cycles after pulse end during which edges are ignored; legal range >= 0.
- RETRIGGER, 0: 1 = a qualifying edge during a pulse reloads the pulse counter; 0 = such an edge is ignored.
- IDLE_LEVEL, 1'b1: reset/idle level of the input line (UART idle high).

Ports:
- clk  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- sig_in  in  N_CH  asynchronous inputs, one bit per channel.
- edge_sel  in  2*N_CH  per-channel edge select: 00 off, 01 rise, 10 fall, 11 both.
- sig_out  out  N_CH  one-shot pulses.
- busy  out  N_CH  high while a channel is in ACTIVE or HOLD.
- miss  out  N_CH  one-cycle flag, high when a qualifying edge is discarded.

Behaviour:
- Reset is asynchronous, active-low. On RSTn low:
  - synchroniser flops and edge-history flop of every channel = IDLE_LEVEL, so no spurious edge at reset release;
  - sig_out, busy, miss = 0; all channel FSMs = IDLE; counters = 0.
- Synchroniser: sig_in[i] passes through SYNC_STAGES flops to give s[i]. Edge history h[i] = s[i] delayed one cycle.
- Edge qualification: rise = s & ~h; fall = ~s & h; qualified edge q = edge selected by edge_sel[i] (edge_sel 00 → q never asserts).
- edge_sel is sampled every cycle and not synchronised. A change applies from the next qualification. Changing edge_sel to off while ACTIVE/HOLD does not abort the current pulse or hold-off.
- Latency: a sig_in transition stable before clock edge k produces sig_out high from edge k+SYNC_STAGES+1 (default: 3 cycles).
- Per-channel FSM:
  - IDLE: on q, load cnt = PULSE_LEN-1, go to ACTIVE; sig_out=1 registered in the same edge.
  - ACTIVE: sig_out=1, busy=1.
    - If q and RETRIGGER=1: cnt reloads to PULSE_LEN-1.
    - If q and RETRIGGER=0: q is discarded and miss pulses for 1 cycle.
    - Else if cnt==0: go to HOLD with cnt=HOLDOFF-1 if HOLDOFF>0, otherwise go to IDLE.
    - Else cnt decrements.
  - HOLD: sig_out=0, busy=1. q is discarded (miss pulses). At cnt==0 go to IDLE; else cnt decrements.
- An edge arriving in the cycle IDLE is re-entered is accepted on the next cycle, provided s still differs from h at that point. Discarded edges are never queued.
- Counter width = $clog2(max(PULSE_LEN,HOLDOFF,1)+1). No wrap: the counter only ever decrements from a loaded value down to 0.
- Channels are fully independent; simultaneous edges on several channels are each serviced in the same cycle.
- Reset mid-pulse: outputs drop asynchronously. After release, the FSM is IDLE and no pulse is produced unless a new edge occurs after the synchroniser refills.
- Pulses shorter than one clock on sig_in may be missed (no pulse stretching); this is acceptable.

Decomposition:
- Package one_shot_pkg holds:
  - edge_sel_t enum {ES_OFF, ES_RISE, ES_FALL, ES_BOTH};
  - state_t enum {ST_IDLE, ST_ACTIVE, ST_HOLD};
  - function cnt_width(pulse_len, holdoff).
- Sub-module one_shot_ch holds one channel (synchroniser, edge detect, FSM, counter). The top instantiates it N_CH times via generate and does only bus slicing.

Test Plan:
- Reset with sig_in=all 1s, release RSTn, hold 20 cycles → sig_out=0, busy=0, miss=0 throughout; no pulse at release.
- Defaults, ch0 edge_sel=10, sig_in[0] 1→0 before edge k → sig_out[0]=1 exactly at edge k+3 for 1 cycle. A 0→1 transition produces no pulse; with edge_sel=11 it produces a pulse.
- PULSE_LEN=4, HOLDOFF=3, RETRIGGER=0, falling edges 2 cycles apart (via sig_in toggling) → sig_out high for 4 cycles; miss=1 for each edge landing in ACTIVE/HOLD; busy high 7 cycles total.
- Same configuration with RETRIGGER=1, a second edge 2 cycles into the pulse → sig_out high for 2+4=6 cycles continuous; miss stays 0.
- N_CH=4, simultaneous falling edges on ch0 and ch2 with edge_sel ch1=00 → sig_out=4'b0101 in the same cycle; ch1 remains silent.
- RSTn asserted at cycle 2 of a PULSE_LEN=4 pulse → sig_out=0 immediately (asynchronously). Release with sig_in steady → no pulse; a new falling edge → a normal 4-cycle pulse.
